result_sram_reader: RTL and testbench
=====================================

# result_sram_reader

Drains the cracked-password result SRAM written by the crack controller. On a start pulse it sweeps all 64 result slots (slot k at word address k·16), issues one SRAM read per slot, and streams each slot's 128-bit password string to the host side over a valid/ready handshake. It sits between the shared result SRAM read port and the host output interface. It is the read-side counterpart of the controller's write-on-match path.

## Interface
- SLOTS, 64: number of result slots swept; fixed to 64 in this design.
- ADDR_STRIDE, 16: word-address distance between consecutive slots.
- READ_LATENCY, 1: cycles from the read_enable cycle to valid read_data; legal range 1..3.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle sweep request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of sweep.
- sram_grant  in  1  read port granted this cycle; reads are issued only when high.
- read_enable  out  1  SRAM read strobe.
- address  out  [0:9]  SRAM word address; address[0:5] = slot, address[6:9] = 0.
- read_data  in  [0:127]  SRAM read data.
- out_valid  out  1  record available.
- out_ready  in  1  sink accepts record.
- out_slot  out  [0:5]  slot index of presented record.
- out_str  out  [0:127]  password string of presented record.
- out_count  out  [0:6]  records emitted this sweep (0..64); holds until next start.

## Operation
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE: if start → ISSUE, slot=0, out_count=0. start is ignored in every other state.
- ISSUE: if sram_grant → read_enable=1, address=slot·16, load latency counter with READ_LATENCY, → WAIT. If sram_grant=0 → stay, read_enable=0.
- WAIT: count down. On the cycle read_data is valid, capture it into the output register, → PRESENT.
- PRESENT: out_valid=1. out_slot and out_str are held stable until out_ready=1. On handshake: out_count+1; if slot==63 → DONE, else slot+1 → ISSUE.
- DONE: done=1 for one cycle → IDLE.
- The slot counter is 6 bits. Increment from 63 never occurs: DONE is taken instead. There is no wrap.
- read_enable=0 and address=0 in every state other than a granted ISSUE.
- rst at any point, including mid-sweep with out_valid high: next cycle IDLE, and all outputs 0. A partially drained record is dropped.

## Timing
- Reset values: busy=0, done=0, read_enable=0, address=0, out_valid=0, out_slot=0, out_str=0, out_count=0.
- Start sampled in cycle 0 → ISSUE in cycle 1.
- Read strobed in cycle t → read_data sampled in cycle t+READ_LATENCY → out_valid in cycle t+READ_LATENCY+1.
- Per slot, with grant and ready held high: READ_LATENCY+2 cycles.
- Full sweep, READ_LATENCY=1, grant/ready always high: last handshake in cycle 192, done in cycle 193, IDLE in cycle 194.
- busy is high in cycles 1..193.
- Each cycle sram_grant is low in ISSUE adds one cycle of delay.
- Each cycle out_ready is low in PRESENT adds one cycle of delay.

## Configuration
- SKIP_EMPTY_EN defined: a captured all-zero read_data word is not presented. The FSM advances directly from WAIT to ISSUE (next slot), or to DONE if slot==63. out_count counts only presented records. An empty slot costs READ_LATENCY+1 cycles.
- SKIP_EMPTY_EN undefined: all 64 slots are presented, including all-zero words. out_count=64 at done.

## Structure
- Package result_reader_pkg holds:
  - state enum;
  - SLOT_W=6, ADDR_W=10, STR_W=128;
  - LAST_SLOT=63, ADDR_STRIDE=16.
- One sub-module, read_latency_pipe: a READ_LATENCY-deep valid shift register that produces the capture strobe from read_enable. The top level contains the FSM, slot/count counters, and output register.

## Test plan
- Reset mid-sweep with READ_LATENCY=1: start, stall ready at slot 5, assert rst → next cycle out_valid=0, busy=0, out_count=0, state IDLE.
- Full sweep, READ_LATENCY=1, grant/ready high, SRAM word k = k+1 → 64 records with out_slot=k, out_str=k+1; done in cycle 193; out_count=64.
- Back-pressure: out_ready low 4 cycles at slot 10 → out_slot=10 and out_str held stable all 4 cycles; no read_enable issued during the stall; slot 11 address=176 afterwards.
- Grant stall plus latency: READ_LATENCY=3, sram_grant low 2 cycles at slot 0 → read_enable first in cycle 3 with address 0; out_valid in cycle 7.
- SKIP_EMPTY_EN defined, slots 2 and 40 non-zero only → exactly 2 records (out_slot 2, then 40); out_count=2; done pulses once.
- start held high across the sweep and DONE → exactly one sweep per IDLE entry; a new sweep begins the cycle after returning to IDLE.

Source files
------------

// File: rtl/result_sram_reader_pkg.sv
// Shared types and geometry for the result SRAM reader.
package result_reader_pkg;

   localparam int SLOTS       = 64;
   localparam int SLOT_W      = 6;
   localparam int ADDR_W      = 10;
   localparam int STR_W       = 128;
   localparam int CNT_W       = 7;
   localparam int ADDR_STRIDE = 16;

   localparam logic [SLOT_W-1:0] LAST_SLOT = 6'd63;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_PRESENT,
      S_DONE
   } state_e;

   function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] s);
      return ADDR_W'(ADDR_W'(s) * ADDR_W'(ADDR_STRIDE));
   endfunction

endpackage

// File: rtl/result_sram_reader_if.sv
// SRAM read port plus host record stream; master is the reader side.
interface result_sram_reader_if;
   import result_reader_pkg::*;

   logic              sram_grant;
   logic              read_enable;
   logic [0:ADDR_W-1] address;
   logic [0:STR_W-1]  read_data;
   logic              out_valid;
   logic              out_ready;
   logic [0:SLOT_W-1] out_slot;
   logic [0:STR_W-1]  out_str;
   logic [0:CNT_W-1]  out_count;

   modport master (
      input  sram_grant, read_data, out_ready,
      output read_enable, address, out_valid, out_slot, out_str, out_count
   );

   modport slave (
      output sram_grant, read_data, out_ready,
      input  read_enable, address, out_valid, out_slot, out_str, out_count
   );

endinterface

// File: rtl/result_sram_reader_latency_pipe.sv
// Valid shift register: capture_o rises exactly LAT cycles after strobe_i.
module read_latency_pipe #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe_i,
   output logic capture_o
);

   logic [LAT-1:0] vld_pipe_q;
   logic [LAT-1:0] vld_pipe_d;

   assign vld_pipe_d = LAT'({vld_pipe_q, strobe_i});

   always_ff @(posedge clk) begin
      if (rst) vld_pipe_q <= '0;
      else     vld_pipe_q <= vld_pipe_d;
   end

   assign capture_o = vld_pipe_q[LAT-1];

endmodule

// File: rtl/result_sram_reader.sv
// Sweeps the 64 result slots, one SRAM read per slot, and streams each record out.
// Build option SKIP_EMPTY_EN: all-zero slots are dropped instead of presented.
module result_sram_reader
   import result_reader_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   output logic                busy_o,
   output logic                done_o,
   result_sram_reader_if.master bus
);

   state_e             state_q;
   logic [SLOT_W-1:0]  slot_q;
   logic [SLOT_W-1:0]  slot_d;
   logic [CNT_W-1:0]   count_q;
   logic               busy_q;
   logic               done_q;
   logic               out_valid_q;
   logic [SLOT_W-1:0]  out_slot_q;
   logic [STR_W-1:0]   out_str_q;
   logic [STR_W-1:0]   rdata;
   logic               issue;
   logic               capture;
   logic               last_slot;
   logic               slot_empty;

   assign issue     = (state_q == S_ISSUE) && bus.sram_grant;
   assign last_slot = (slot_q == LAST_SLOT);
   assign slot_d    = slot_q + SLOT_W'(1);
   assign rdata     = bus.read_data;

   // The pipe replaces a down-counter: its tail marks the cycle read_data is valid.
   read_latency_pipe #(
      .LAT (READ_LATENCY)
   ) u_lat (
      .clk       (clk),
      .rst       (rst),
      .strobe_i  (issue),
      .capture_o (capture)
   );

`ifdef SKIP_EMPTY_EN
   assign slot_empty = (rdata == '0);
`else
   assign slot_empty = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         slot_q      <= '0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_slot_q  <= '0;
         out_str_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_ISSUE;
                  slot_q  <= '0;
                  count_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (bus.sram_grant) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (capture) begin
                  if (slot_empty) begin
                     // Dropped slot: move straight on without touching the output register.
                     if (last_slot) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        slot_q  <= slot_d;
                        state_q <= S_ISSUE;
                     end
                  end else begin
                     out_str_q   <= rdata;
                     out_slot_q  <= slot_q;
                     out_valid_q <= 1'b1;
                     state_q     <= S_PRESENT;
                  end
               end
            end
            S_PRESENT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  count_q     <= count_q + CNT_W'(1);
                  if (last_slot) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     slot_q  <= slot_d;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Strobe and address follow the grant combinationally so the read lands in the granted cycle.
   assign bus.read_enable = issue;
   assign bus.address     = issue ? slot_addr(slot_q) : '0;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_slot    = out_slot_q;
   assign bus.out_str     = out_str_q;
   assign bus.out_count   = count_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;

endmodule

// File: tb/tb_result_sram_reader.sv
// Bench for result_sram_reader: one DUT at READ_LATENCY=1, one at 3, each with an SRAM model.
module tb_result_sram_reader;
   import result_reader_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic         start_s [2];
   logic         grant_s [2];
   logic         ready_s [2];
   logic         busy_w  [2];
   logic         done_w  [2];
   logic         re_w    [2];
   logic         ov_w    [2];
   logic [9:0]   addr_w  [2];
   logic [5:0]   oslot_w [2];
   logic [127:0] ostr_w  [2];
   logic [6:0]   ocnt_w  [2];

   logic [127:0] mem [2][64];
   logic [127:0] rdata0, p1, p2, rdata1;
   logic         busy0, busy1, done0, done1;

   result_sram_reader_if b0();
   result_sram_reader_if b1();

   result_sram_reader #(.READ_LATENCY(1)) u_rl1 (
      .clk(clk), .rst(rst), .start_i(start_s[0]), .busy_o(busy0), .done_o(done0), .bus(b0.master));
   result_sram_reader #(.READ_LATENCY(3)) u_rl3 (
      .clk(clk), .rst(rst), .start_i(start_s[1]), .busy_o(busy1), .done_o(done1), .bus(b1.master));

   always_comb begin
      b0.sram_grant = grant_s[0];
      b0.out_ready  = ready_s[0];
      b0.read_data  = rdata0;
      b1.sram_grant = grant_s[1];
      b1.out_ready  = ready_s[1];
      b1.read_data  = rdata1;
      busy_w[0] = busy0;          busy_w[1] = busy1;
      done_w[0] = done0;          done_w[1] = done1;
      re_w[0]   = b0.read_enable; re_w[1]   = b1.read_enable;
      addr_w[0] = b0.address;     addr_w[1] = b1.address;
      ov_w[0]   = b0.out_valid;   ov_w[1]   = b1.out_valid;
      oslot_w[0] = b0.out_slot;   oslot_w[1] = b1.out_slot;
      ostr_w[0] = b0.out_str;     ostr_w[1] = b1.out_str;
      ocnt_w[0] = b0.out_count;   ocnt_w[1] = b1.out_count;
   end

   // SRAM models: data appears exactly READ_LATENCY cycles after the strobe, junk otherwise.
   always @(posedge clk) begin
      rdata0 <= re_w[0] ? mem[0][addr_w[0][9:4]] : {$urandom, $urandom, $urandom, $urandom};
      p1     <= re_w[1] ? mem[1][addr_w[1][9:4]] : {$urandom, $urandom, $urandom, $urandom};
      p2     <= p1;
      rdata1 <= p2;
   end

   task automatic fill_count(input int d);
      for (int k = 0; k < 64; k++) mem[d][k] = 128'(k + 1);
   endtask

   task automatic sweep(input int d, input int gp, input int rp, input int stall_slot,
                        input int stall_n, input int gstall_n, input bit hold,
                        input int exp_first_re, input int exp_first_ov, input int exp_done);
      logic [5:0]   eslot[$];
      logic [127:0] estr[$];
      int cyc = 0, rd_slot = 0, first_re = -1, first_ov = -1;
      int done_cyc = -1, done_cnt = 0, last_hs = -1, stalls = 0, n_exp;
      bit pv = 0, pr = 0;
      logic [5:0]   ps = '0;
      logic [127:0] pstr = '0;
      bit exp_busy;
      for (int k = 0; k < 64; k++) begin
`ifdef SKIP_EMPTY_EN
         if (mem[d][k] == '0) continue;
`endif
         eslot.push_back(6'(k));
         estr.push_back(mem[d][k]);
      end
      n_exp = eslot.size();
      @(posedge clk); #1 start_s[d] = 1'b1;
      while ((done_cyc < 0 || cyc <= done_cyc) && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (!hold) start_s[d] = 1'b0;
         grant_s[d] = (cyc > gstall_n) && ($urandom_range(99) < gp);
         ready_s[d] = ($urandom_range(99) < rp);
         if (ov_w[d] && oslot_w[d] == stall_slot && stalls < stall_n) begin
            ready_s[d] = 1'b0;
            stalls++;
         end
         #1;
         if (pv && !pr) begin
            n_chk++;
            if (ov_w[d] !== 1'b1 || oslot_w[d] !== ps || ostr_w[d] !== pstr) begin
               n_fail++;
               $display("FAIL hold_stable d=%0d cyc=%0d got v=%b s=%0d str=%h exp s=%0d str=%h",
                        d, cyc, ov_w[d], oslot_w[d], ostr_w[d], ps, pstr);
            end
         end
         if (re_w[d]) begin
            n_chk++;
            if (!grant_s[d] || ov_w[d] || addr_w[d] !== 10'(rd_slot * 16)) begin
               n_fail++;
               $display("FAIL read_issue d=%0d cyc=%0d got addr=%0d grant=%b valid=%b exp addr=%0d",
                        d, cyc, addr_w[d], grant_s[d], ov_w[d], rd_slot * 16);
            end
            if (first_re < 0) first_re = cyc;
            rd_slot++;
         end
         if (ov_w[d] && first_ov < 0) first_ov = cyc;
         if (ov_w[d] && ready_s[d]) begin
            n_chk++;
            if (eslot.size() == 0) begin
               n_fail++;
               $display("FAIL record d=%0d cyc=%0d got extra slot=%0d", d, cyc, oslot_w[d]);
            end else begin
               if (oslot_w[d] !== eslot[0] || ostr_w[d] !== estr[0]) begin
                  n_fail++;
                  $display("FAIL record d=%0d cyc=%0d got s=%0d str=%h exp s=%0d str=%h",
                           d, cyc, oslot_w[d], ostr_w[d], eslot[0], estr[0]);
               end
               void'(eslot.pop_front());
               void'(estr.pop_front());
            end
            last_hs = cyc;
         end
         if (done_w[d]) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            n_chk++;
            if (ocnt_w[d] !== 7'(n_exp)) begin
               n_fail++;
               $display("FAIL out_count d=%0d got %0d exp %0d", d, ocnt_w[d], n_exp);
            end
         end
         exp_busy = (done_cyc < 0) || (cyc == done_cyc);
         n_chk++;
         if (busy_w[d] !== exp_busy) begin
            n_fail++;
            $display("FAIL busy d=%0d cyc=%0d got %b exp %b", d, cyc, busy_w[d], exp_busy);
         end
         pv = ov_w[d]; pr = ready_s[d]; ps = oslot_w[d]; pstr = ostr_w[d];
      end
      grant_s[d] = 1'b0;
      ready_s[d] = 1'b0;
      n_chk++;
      if (done_cyc < 0) begin
         n_fail++;
         $display("FAIL sweep_timeout d=%0d got no done exp done", d);
      end
      n_chk++;
      if (eslot.size() != 0 || done_cnt != 1 || rd_slot != 64) begin
         n_fail++;
         $display("FAIL sweep_totals d=%0d got left=%0d dones=%0d reads=%0d exp 0/1/64",
                  d, eslot.size(), done_cnt, rd_slot);
      end
      if (stall_n > 0) begin
         n_chk++;
         if (stalls != stall_n) begin
            n_fail++;
            $display("FAIL stall_count d=%0d got %0d exp %0d", d, stalls, stall_n);
         end
      end
      if (exp_first_re >= 0) begin
         n_chk++;
         if (first_re != exp_first_re || first_ov != exp_first_ov) begin
            n_fail++;
            $display("FAIL first_timing d=%0d got re=%0d ov=%0d exp re=%0d ov=%0d",
                     d, first_re, first_ov, exp_first_re, exp_first_ov);
         end
      end
      if (exp_done >= 0) begin
         n_chk++;
         if (done_cyc != exp_done || last_hs != exp_done - 1) begin
            n_fail++;
            $display("FAIL done_timing d=%0d got done=%0d last_hs=%0d exp done=%0d last_hs=%0d",
                     d, done_cyc, last_hs, exp_done, exp_done - 1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || re_w[d] !== 1'b0 || addr_w[d] !== '0 ||
             ov_w[d] !== 1'b0 || oslot_w[d] !== '0 || ostr_w[d] !== '0 || ocnt_w[d] !== '0) begin
            n_fail++;
            $display("FAIL reset_state d=%0d got busy=%b done=%b re=%b addr=%0d v=%b s=%0d cnt=%0d exp all 0",
                     d, busy_w[d], done_w[d], re_w[d], addr_w[d], ov_w[d], oslot_w[d], ocnt_w[d]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_full_sweep();
      fill_count(0);
      sweep(0, 100, 100, -1, 0, 0, 1'b0, 1, 3, 193);
   endtask

   task automatic test_backpressure();
      fill_count(0);
      sweep(0, 100, 100, 10, 4, 0, 1'b0, 1, 3, 197);
   endtask

   task automatic test_grant_latency();
      fill_count(1);
      sweep(1, 100, 100, -1, 0, 2, 1'b0, 3, 7, 323);
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      bit hit = 0;
      fill_count(0);
      grant_s[0] = 1'b1;
      ready_s[0] = 1'b1;
      @(posedge clk); #1 start_s[0] = 1'b1;
      while (!hit && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         start_s[0] = 1'b0;
         if (ov_w[0] && oslot_w[0] == 6'd5) begin
            hit = 1;
            ready_s[0] = 1'b0;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (!hit || ov_w[0] !== 1'b1 || ocnt_w[0] !== 7'd5) begin
         n_fail++;
         $display("FAIL pre_reset d=0 got hit=%b v=%b cnt=%0d exp 1/1/5", hit, ov_w[0], ocnt_w[0]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if (ov_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || ocnt_w[0] !== '0 || oslot_w[0] !== '0 ||
          ostr_w[0] !== '0 || re_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got v=%b busy=%b cnt=%0d s=%0d re=%b exp all 0",
                  ov_w[0], busy_w[0], ocnt_w[0], oslot_w[0], re_w[0]);
      end
      rst = 1'b0;
      ready_s[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (busy_w[0] !== 1'b0 || re_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle got busy=%b re=%b exp 0/0", busy_w[0], re_w[0]);
      end
      grant_s[0] = 1'b0;
      ready_s[0] = 1'b0;
   endtask

   task automatic test_skip_empty();
      for (int k = 0; k < 64; k++) mem[0][k] = '0;
      mem[0][2]  = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      mem[0][40] = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      sweep(0, 100, 100, -1, 0, 0, 1'b0, -1, -1, -1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 2; it++) begin
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 64; k++)
               mem[d][k] = ($urandom_range(3) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            sweep(d, 60, 60, -1, 0, 0, 1'b0, -1, -1, -1);
         end
      end
   endtask

   task automatic test_start_held();
      fill_count(0);
      sweep(0, 100, 100, -1, 0, 0, 1'b1, 1, 3, 193);
      @(posedge clk); #1;
      n_chk++;
      if (busy_w[0] !== 1'b1 || ocnt_w[0] !== '0) begin
         n_fail++;
         $display("FAIL restart got busy=%b cnt=%0d exp 1/0", busy_w[0], ocnt_w[0]);
      end
      start_s[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         grant_s[d] = 1'b0;
         ready_s[d] = 1'b0;
      end
      test_reset();
      test_full_sweep();
      test_backpressure();
      test_grant_latency();
      test_reset_mid();
      test_skip_empty();
      test_random();
      test_start_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
